t_using_d_ff: RTL and testbench
===============================

Name:
t_using_d_ff

Overview:
- Toggle (T) flip-flop built from a D flip-flop plus XOR feedback: D = q XOR T.
- Generic storage/toggle primitive for counters, dividers and parity state in the design.
- Parameterised to a WIDTH-bit bank of independent T flops that share one clock and one reset.

Parameters:
- WIDTH, 1, number of independent T flip-flop bits.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into q while rst is asserted.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high; forces q to RESET_VALUE.
- T  input  WIDTH  per-bit toggle request; 1 means invert that bit at the next rising clk edge.
- q  output  WIDTH  registered flip-flop state.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset:
  - q goes to RESET_VALUE immediately when rst rises, with no clk edge needed.
  - q holds RESET_VALUE for as long as rst is high, regardless of clk or T.
  - Default reset value is all zeros.
- Normal operation (rst low), at each rising clk edge, for each bit i:
  - q[i] <= q[i] ^ T[i].
  - T[i]=1: bit toggles. T[i]=0: bit holds.
- Latency: one clk edge from T sampled to q updated. No combinational path from T to q.
- Sampling: T is sampled only at the rising edge. Changes or glitches between edges have no effect.
- Reset deasserted coincident with a clk edge: reset wins for that edge and q stays RESET_VALUE. The first toggle happens at the following edge.
- Reset asserted mid-operation, including between edges: q clears at once. Pending toggle intent is lost.
- Bits are fully independent. No carry or interaction between bits.
- X on T while rst is low propagates X into q at the next edge. Verification treats this as an illegal stimulus.
- Internal structure:
  - XOR stage computes next = q ^ T.
  - A WIDTH-bit D flip-flop with asynchronous active-high reset stores next.
  - q is driven directly from the D flip-flop output.

Decomposition:
- Shared package: a WIDTH default constant and a reset-value constant, so dependent blocks (counters, dividers) stay consistent.
- One sub-module, d_ff_async_rst:
  - Ports: clk, rst, d (WIDTH), q (WIDTH); parameters WIDTH and RESET_VALUE.
  - Behaviour: asynchronous active-high reset to RESET_VALUE, otherwise q <= d on the rising edge.
- t_using_d_ff instantiates d_ff_async_rst and contains only the XOR feedback.

Test Plan:
- Bench clock: 10 ns period, rising edges at 5, 15, 25, ... ns.
- Reset hold: rst=1 from t=0 to 7 ns, T toggling every 8 ns -> q=0 at every edge while rst=1.
- Continuous toggle: rst=0, T=1 held for 4 edges starting from q=0 -> q sequence 1,0,1,0.
- Hold: q=1, T=0 for 3 edges -> q stays 1. A T pulse high for 2 ns that ends before the next edge -> q stays 1.
- Async reset mid-cycle: q=1, raise rst 2 ns after an edge -> q=0 within the same cycle. Hold rst for 10 ns, then drop it with T=1 -> q=1 at the first edge after release.
- Reset release coincident with an edge, T=1 -> q stays 0 at that edge and becomes 1 at the next edge.
- WIDTH=4, RESET_VALUE=4'b0101:
  - During reset -> q=0101.
  - After release, T=4'b1010 -> q=1111 after the first edge, then 0101 after the second edge.
  - T=4'b0001 -> q=0100.

Source files
------------

// File: rtl/t_using_d_ff_pkg.sv
// Purpose: shared constants for the T flip-flop bank and the blocks built on it.
// Latency: n/a (constants only).
// Backpressure: n/a.
package t_using_d_ff_pkg;

    // Default bank width when a user instantiates a single toggle bit.
    localparam int unsigned T_FF_WIDTH = 1;

    // Per-bit reset level. Counters and dividers derive their reset vectors from it.
    localparam logic T_FF_RESET_BIT = 1'b0;

endpackage : t_using_d_ff_pkg

// File: rtl/t_using_d_ff_d_ff_async_rst.sv
// Purpose: WIDTH-bit D register with asynchronous active-high reset.
// Latency: d appears on q one rising clk edge after it is sampled.
// Backpressure: none; the register captures d on every edge.
//
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous, active-high; forces q to RESET_VALUE
//   d   - next-state input, sampled at the rising clk edge
//   q   - registered state
module d_ff_async_rst
    import t_using_d_ff_pkg::*;
#(
    parameter int unsigned      WIDTH       = T_FF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{T_FF_RESET_BIT}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else begin
            q <= d;
        end
    end

endmodule : d_ff_async_rst

// File: rtl/t_using_d_ff.sv
// Purpose: bank of WIDTH independent T flip-flops (D register plus XOR feedback).
// Latency: one rising clk edge from T sampled to q updated; no comb path T->q.
// Backpressure: none; a toggle request is honoured on every edge.
//
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous, active-high; forces q to RESET_VALUE
//   T   - per-bit toggle request; 1 inverts that bit at the next rising edge
//   q   - registered flip-flop state
module t_using_d_ff
    import t_using_d_ff_pkg::*;
#(
    parameter int unsigned      WIDTH       = T_FF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{T_FF_RESET_BIT}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] T,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] next;

    // Each bit flips where T is set and holds elsewhere; bits never interact.
    assign next = q ^ T;

    d_ff_async_rst #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_state (
        .clk (clk),
        .rst (rst),
        .d   (next),
        .q   (q)
    );

endmodule : t_using_d_ff

// File: tb/tb_t_using_d_ff.sv
`timescale 1ns/1ps
module tb_t_using_d_ff;

    logic       clk = 1'b0;
    logic       rst1;
    logic [0:0] t1;
    logic [0:0] q1;
    logic       rst4;
    logic [3:0] t4;
    logic [3:0] q4;

    int checks = 0;
    int errors = 0;

    // Rising edges at 5, 15, 25, ... ns.
    always #5 clk = ~clk;

    t_using_d_ff u_dut1 (
        .clk (clk),
        .rst (rst1),
        .T   (t1),
        .q   (q1)
    );

    t_using_d_ff #(
        .WIDTH       (4),
        .RESET_VALUE (4'b0101)
    ) u_dut4 (
        .clk (clk),
        .rst (rst4),
        .T   (t4),
        .q   (q4)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic wait_until(input time t);
        if (t > $time) #(t - $time);
    endtask

    initial begin
        // Reset hold: both banks in reset, toggle requests active.
        rst1 = 1'b1;
        t1   = 1'b1;
        rst4 = 1'b1;
        t4   = 4'b1111;
        wait_until(1);
        check("rst_initial_w1", {3'b000, q1}, 4'b0000);
        check("rst_initial_w4", q4, 4'b0101);
        wait_until(4);
        t1 = 1'b0;
        wait_until(5);
        t1 = 1'b1;
        wait_until(6);
        check("rst_hold_edge5_w1", {3'b000, q1}, 4'b0000);
        check("rst_hold_edge5_w4", q4, 4'b0101);

        // Continuous toggle from q=0: 1,0,1,0 at edges 15..45.
        wait_until(7);
        rst1 = 1'b0;
        t1   = 1'b1;
        wait_until(16);
        check("toggle_1", {3'b000, q1}, 4'b0001);
        wait_until(26);
        check("toggle_2", {3'b000, q1}, 4'b0000);
        wait_until(36);
        check("toggle_3", {3'b000, q1}, 4'b0001);
        wait_until(46);
        check("toggle_4", {3'b000, q1}, 4'b0000);

        // Bring q to 1, then hold with T=0 for three edges.
        wait_until(56);
        check("toggle_5", {3'b000, q1}, 4'b0001);
        t1 = 1'b0;
        wait_until(66);
        check("hold_1", {3'b000, q1}, 4'b0001);
        wait_until(76);
        check("hold_2", {3'b000, q1}, 4'b0001);
        wait_until(86);
        check("hold_3", {3'b000, q1}, 4'b0001);

        // A short T pulse between edges is never sampled.
        wait_until(87);
        t1 = 1'b1;
        wait_until(89);
        t1 = 1'b0;
        wait_until(96);
        check("glitch_ignored", {3'b000, q1}, 4'b0001);

        // Async reset 2 ns after edge 95 clears q before the next edge.
        wait_until(97);
        rst1 = 1'b1;
        t1   = 1'b1;
        wait_until(98);
        check("async_rst_midcycle", {3'b000, q1}, 4'b0000);
        wait_until(106);
        check("async_rst_held", {3'b000, q1}, 4'b0000);
        wait_until(107);
        rst1 = 1'b0;
        t1   = 1'b1;
        wait_until(116);
        check("first_toggle_after_release", {3'b000, q1}, 4'b0001);

        // Reset released exactly on edge 125: reset wins there.
        wait_until(117);
        rst1 = 1'b1;
        wait_until(118);
        check("rst_before_coincident", {3'b000, q1}, 4'b0000);
        @(posedge clk);
        // Nonblocking so the register still sees rst high on this same edge.
        rst1 <= 1'b0;
        wait_until(126);
        check("coincident_release_edge", {3'b000, q1}, 4'b0000);
        wait_until(136);
        check("coincident_release_next", {3'b000, q1}, 4'b0001);

        // WIDTH=4 bank, RESET_VALUE=0101, still in reset.
        wait_until(137);
        check("w4_rst_long_hold", q4, 4'b0101);
        t4 = 4'b1010;
        wait_until(138);
        rst4 = 1'b0;
        wait_until(146);
        check("w4_toggle_1010_a", q4, 4'b1111);
        wait_until(156);
        check("w4_toggle_1010_b", q4, 4'b0101);
        t4 = 4'b0001;
        wait_until(166);
        check("w4_toggle_0001", q4, 4'b0100);
        t4 = 4'b0000;
        wait_until(176);
        check("w4_hold", q4, 4'b0100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_t_using_d_ff
